// File: rtl/regfile_wb_pkg.sv
// Shared decode/writeback definitions: word and index types, opcode and load
// funct3 constants, and instruction field / register-usage helpers.
package regfile_wb_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [6:0]  opcode_t;

    localparam word_t NOP = 32'h0000_0013;

    localparam opcode_t OPC_OP       = 7'b0110011;
    localparam opcode_t OPC_OP_IMM   = 7'b0010011;
    localparam opcode_t OPC_LUI      = 7'b0110111;
    localparam opcode_t OPC_AUIPC    = 7'b0010111;
    localparam opcode_t OPC_JAL      = 7'b1101111;
    localparam opcode_t OPC_JALR     = 7'b1100111;
    localparam opcode_t OPC_LOAD     = 7'b0000011;
    localparam opcode_t OPC_STORE    = 7'b0100011;
    localparam opcode_t OPC_BRANCH   = 7'b1100011;
    localparam opcode_t OPC_MISC_MEM = 7'b0001111;
    localparam opcode_t OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic opcode_t ext_opcode(input word_t instr);
        return instr[6:0];
    endfunction

    function automatic reg_idx_t rd_of(input word_t instr);
        return instr[11:7];
    endfunction

    function automatic reg_idx_t rs1_of(input word_t instr);
        return instr[19:15];
    endfunction

    function automatic reg_idx_t rs2_of(input word_t instr);
        return instr[24:20];
    endfunction

    function automatic logic writes_rd(input word_t instr);
        case (ext_opcode(instr))
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: return rd_of(instr) != '0;
            default:                     return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input word_t instr);
        case (ext_opcode(instr))
            OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b0;
            default:                     return 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input word_t instr);
        case (ext_opcode(instr))
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Decode/writeback bundle between the pipeline (master) and the register file (slave).
interface regfile_wb_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] instr_d;
    logic            issue_d;
    logic            wb_valid;
    logic [XLEN-1:0] wb_instr;
    logic [XLEN-1:0] wb_alu;
    logic [XLEN-1:0] wb_mem_data;
    logic [XLEN-1:0] r1_val;
    logic [XLEN-1:0] r2_val;
    logic            stall_d;

    modport master (
        output instr_d, issue_d, wb_valid, wb_instr, wb_alu, wb_mem_data,
        input  r1_val, r2_val, stall_d
    );

    modport slave (
        input  instr_d, issue_d, wb_valid, wb_instr, wb_alu, wb_mem_data,
        output r1_val, r2_val, stall_d
    );
endinterface

// File: rtl/regfile_wb_load_align.sv
// Combinational load aligner: picks the byte/half lane from a raw memory word
// and sign- or zero-extends it; unknown funct3 falls back to a full word.
module regfile_wb_load_align
    import regfile_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            default: data = raw;
        endcase
    end
endmodule

// File: rtl/regfile_wb.sv
// Integer register file with writeback retire, same-cycle read bypass and a
// per-register busy scoreboard that stalls decode on RAW/WAW hazards.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic         clk,
    input logic         rst,
    regfile_wb_if.slave bus
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_we;
    logic            set_en;
    reg_idx_t        rd_wb;
    reg_idx_t        rd_d;
    reg_idx_t        rs1_d;
    reg_idx_t        rs2_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] eff_busy;

    regfile_wb_load_align #(.XLEN(XLEN)) u_load_align (
        .funct3 (bus.wb_instr[14:12]),
        .offset (bus.wb_alu[1:0]),
        .raw    (bus.wb_mem_data),
        .data   (load_data)
    );

    always_comb begin
        rd_wb   = rd_of(bus.wb_instr);
        rd_d    = rd_of(bus.instr_d);
        rs1_d   = rs1_of(bus.instr_d);
        rs2_d   = rs2_of(bus.instr_d);
        wb_we   = !rst && bus.wb_valid && writes_rd(bus.wb_instr);
        set_en  = !rst && bus.issue_d && writes_rd(bus.instr_d);
        wb_data = (ext_opcode(bus.wb_instr) == OPC_LOAD) ? load_data : bus.wb_alu;

        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[rd_d]  = 1'b1;
        if (wb_we)  clr_mask[rd_wb] = 1'b1;

        // Set after clear so an issue and a retire to the same rd leave it busy.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        eff_busy  = busy_q & ~clr_mask;

        regs_d = regs_q;
        if (wb_we) regs_d[rd_wb] = wb_data;
        regs_d[0] = '0;
    end

    always_comb begin
        if (rs1_d == '0)                 bus.r1_val = '0;
        else if (wb_we && rd_wb == rs1_d) bus.r1_val = wb_data;
        else                             bus.r1_val = regs_q[rs1_d];

        if (rs2_d == '0)                 bus.r2_val = '0;
        else if (wb_we && rd_wb == rs2_d) bus.r2_val = wb_data;
        else                             bus.r2_val = regs_q[rs2_d];

        bus.stall_d = !rst && (
                          (uses_rs1(bus.instr_d)  && eff_busy[rs1_d]) ||
                          (uses_rs2(bus.instr_d)  && eff_busy[rs2_d]) ||
                          (writes_rd(bus.instr_d) && eff_busy[rd_d]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: a vector table for read/write/bypass/load
// alignment, plus hand sequences for scoreboard stalls, collisions and reset.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_if #(.XLEN(32)) bus ();

    regfile_wb #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        issue;
        logic        wbv;
        logic [31:0] wbi;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic        e_st;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic issue, input logic wbv,
                                input logic [31:0] wbi, input logic [31:0] alu,
                                input logic [31:0] mem, input logic [31:0] e_r1,
                                input logic [31:0] e_r2, input logic e_st);
        vec_t v;
        v.instr = instr; v.issue = issue; v.wbv = wbv; v.wbi = wbi; v.alu = alu;
        v.mem = mem; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic issue, input logic wbv,
                         input logic [31:0] wbi, input logic [31:0] alu, input logic [31:0] mem);
        bus.instr_d = instr; bus.issue_d = issue; bus.wb_valid = wbv;
        bus.wb_instr = wbi; bus.wb_alu = alu; bus.wb_mem_data = mem;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Decode must never advance while stalled.
    always @(negedge clk) begin
        if (!rst && bus.issue_d && bus.stall_d) begin
            errors++;
            $display("FAIL issue_while_stalled: issue_d=1 stall_d=1 required issue_d=0");
        end
    end

    initial begin
        logic [31:0] add3, rd11, mem_pat;
        add3    = enc_r(5'd3, 5'd1, 5'd2);
        rd11    = enc_r(5'd12, 5'd11, 5'd0);
        mem_pat = 32'h8070_F0A5;

        vecs[0]  = mk(add3, 0, 0, NOP, 0, 0, 0, 0, 0);
        vecs[1]  = mk(NOP, 0, 1, enc_i(OPC_OP_IMM, 0, 5'd5, 0, 0), 32'h0000_1234, 0, 0, 0, 0);
        vecs[2]  = mk(enc_r(5'd6, 5'd5, 5'd0), 0, 0, NOP, 0, 0, 32'h0000_1234, 0, 0);
        vecs[3]  = mk(enc_r(5'd6, 5'd0, 5'd5), 0, 1, enc_i(OPC_OP_IMM, 0, 5'd0, 0, 0),
                      32'hFFFF_FFFF, 0, 0, 32'h0000_1234, 0);
        vecs[4]  = mk(enc_r(5'd6, 5'd0, 5'd0), 0, 0, NOP, 0, 0, 0, 0, 0);
        vecs[5]  = mk(enc_r(5'd8, 5'd1, 5'd7), 0, 1, enc_i(OPC_OP_IMM, 0, 5'd7, 0, 0),
                      32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[6]  = mk(enc_r(5'd8, 5'd7, 5'd5), 0, 0, NOP, 0, 0, 32'hDEAD_BEEF, 32'h0000_1234, 0);
        vecs[7]  = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LB,  5'd11, 0, 0), 32'h100, mem_pat, 32'hFFFF_FFA5, 0, 0);
        vecs[8]  = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LBU, 5'd11, 0, 0), 32'h101, mem_pat, 32'h0000_00F0, 0, 0);
        vecs[9]  = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LH,  5'd11, 0, 0), 32'h102, mem_pat, 32'hFFFF_8070, 0, 0);
        vecs[10] = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LHU, 5'd11, 0, 0), 32'h100, mem_pat, 32'h0000_F0A5, 0, 0);
        vecs[11] = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LW,  5'd11, 0, 0), 32'h103, mem_pat, 32'h8070_F0A5, 0, 0);
        vecs[12] = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LH,  5'd11, 0, 0), 32'h103, mem_pat, 32'hFFFF_8070, 0, 0);
        vecs[13] = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LB,  5'd11, 0, 0), 32'h103, mem_pat, 32'hFFFF_FF80, 0, 0);
        vecs[14] = mk(rd11, 0, 1, enc_i(OPC_LOAD, F3_LBU, 5'd11, 0, 0), 32'h102, mem_pat, 32'h0000_0070, 0, 0);
        vecs[15] = mk(rd11, 0, 1, enc_i(OPC_LOAD, 3'b011, 5'd11, 0, 0), 32'h101, mem_pat, 32'h8070_F0A5, 0, 0);
        vecs[16] = mk(rd11, 0, 0, NOP, 0, 0, 32'h8070_F0A5, 0, 0);
        vecs[17] = mk(rd11, 0, 1, enc_i(OPC_STORE, 3'b010, 5'd11, 5'd1, 0), 32'h55, 0, 32'h8070_F0A5, 0, 0);
        vecs[18] = mk(rd11, 0, 0, NOP, 0, 0, 32'h8070_F0A5, 0, 0);

        rst = 1'b1;
        drive(add3, 0, 0, NOP, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", dut.busy_q, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].instr, vecs[i].issue, vecs[i].wbv, vecs[i].wbi, vecs[i].alu, vecs[i].mem);
            #2;
            chk($sformatf("vec%0d_r1", i), bus.r1_val, vecs[i].e_r1);
            chk($sformatf("vec%0d_r2", i), bus.r2_val, vecs[i].e_r2);
            chk($sformatf("vec%0d_stall", i), {31'd0, bus.stall_d}, {31'd0, vecs[i].e_st});
            next_cycle();
        end

        // RAW / WAW against an in-flight LW x9
        drive(enc_i(OPC_LOAD, F3_LW, 5'd9, 5'd1, 0), 1, 0, NOP, 0, 0);
        #2 chk("raw_issue_lw_stall", {31'd0, bus.stall_d}, 32'd0);
        next_cycle();
        chk("raw_busy9", dut.busy_q, 32'h0000_0200);
        for (int c = 0; c < 2; c++) begin
            drive(enc_r(5'd10, 5'd9, 5'd0), 0, 0, NOP, 0, 0);
            #2 chk($sformatf("raw_stall_c%0d", c), {31'd0, bus.stall_d}, 32'd1);
            next_cycle();
        end
        drive(enc_r(5'd10, 5'd0, 5'd9), 0, 0, NOP, 0, 0);
        #2 chk("raw_rs2_stall", {31'd0, bus.stall_d}, 32'd1);
        drive(enc_i(OPC_OP_IMM, 0, 5'd9, 5'd0, 12'd1), 0, 0, NOP, 0, 0);
        #2 chk("waw_stall", {31'd0, bus.stall_d}, 32'd1);
        drive(enc_i(OPC_LUI, 0, 5'd10, 5'd9, 0), 0, 0, NOP, 0, 0);
        #2 chk("lui_no_rs1_stall", {31'd0, bus.stall_d}, 32'd0);
        drive(enc_i(OPC_OP_IMM, 0, 5'd10, 5'd0, 12'd9), 0, 0, NOP, 0, 0);
        #2 chk("addi_no_rs2_stall", {31'd0, bus.stall_d}, 32'd0);
        next_cycle();
        drive(enc_r(5'd10, 5'd9, 5'd0), 1, 1, enc_i(OPC_LOAD, F3_LW, 5'd9, 5'd1, 0),
              32'h0, 32'hCAFE_F00D);
        #2;
        chk("raw_release_stall", {31'd0, bus.stall_d}, 32'd0);
        chk("raw_release_r1", bus.r1_val, 32'hCAFE_F00D);
        next_cycle();
        chk("raw_busy_after", dut.busy_q, 32'h0000_0400);
        drive(NOP, 0, 1, enc_r(5'd10, 5'd9, 5'd0), 32'h1, 0);
        next_cycle();
        chk("raw_busy_drained", dut.busy_q, 32'h0);

        // Set/clear collision on x4, then reset with x4 busy
        drive(enc_i(OPC_OP_IMM, 0, 5'd4, 5'd0, 12'd1), 1, 0, NOP, 0, 0);
        #2 chk("col_first_issue_stall", {31'd0, bus.stall_d}, 32'd0);
        next_cycle();
        drive(enc_i(OPC_OP_IMM, 0, 5'd4, 5'd0, 12'd2), 1, 1,
              enc_i(OPC_OP_IMM, 0, 5'd4, 5'd0, 0), 32'h44, 0);
        #2 chk("col_waw_masked_stall", {31'd0, bus.stall_d}, 32'd0);
        next_cycle();
        drive(enc_r(5'd1, 5'd4, 5'd0), 0, 0, NOP, 0, 0);
        #2;
        chk("col_busy4", dut.busy_q, 32'h0000_0010);
        chk("col_stall", {31'd0, bus.stall_d}, 32'd1);
        chk("col_r1", bus.r1_val, 32'h44);
        rst = 1'b1;
        drive(enc_r(5'd1, 5'd4, 5'd0), 0, 1, enc_i(OPC_OP_IMM, 0, 5'd13, 0, 0), 32'h77, 0);
        next_cycle();
        rst = 1'b0;
        drive(enc_r(5'd1, 5'd4, 5'd13), 0, 0, NOP, 0, 0);
        #2;
        chk("rst_mid_busy", dut.busy_q, 32'h0);
        chk("rst_mid_stall", {31'd0, bus.stall_d}, 32'd0);
        chk("rst_mid_x4", bus.r1_val, 32'h0);
        chk("rst_mid_wb_ignored", bus.r2_val, 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
